// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

  localparam int   BYTE_BITS = 8;
  localparam logic ACK_BIT   = 1'b0;
  localparam logic NACK_BIT  = 1'b1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RD_MACK   = 4'd8,
    WAIT_STOP = 4'd9
  } i2c_state_e;

  // Address byte carries the 7-bit target address above the R/W bit.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchronizers for SCL/SDA plus SCL edge and START/STOP condition detection.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise_s,
  output logic scl_fall_s,
  output logic start_det_s,
  output logic stop_det_s
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_hist_r;
  logic       sda_hist_r;
  logic       scl_cur_s;

  // Two-flop synchronizers followed by a history flop; idle bus level is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  assign scl_cur_s   = scl_sync_r[1];
  assign sda_s       = sda_sync_r[1];
  assign scl_rise_s  = scl_cur_s & ~scl_hist_r;
  assign scl_fall_s  = ~scl_cur_s & scl_hist_r;
  assign start_det_s = scl_cur_s & scl_hist_r & sda_hist_r & ~sda_s;
  assign stop_det_s  = scl_cur_s & scl_hist_r & ~sda_hist_r & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target exposing an 8-bit register pointer with register write strobe and read port.
// Optional pointer auto-increment is enabled by defining I2C_TARGET_AUTOINC_EN.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1D
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam logic [3:0] LAST_CNT = 4'(BYTE_BITS);

  logic       sda_s, scl_rise_s, scl_fall_s, start_det_s, stop_det_s;
  logic [7:0] byte_in_s;

  i2c_state_e state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] ptr_r, ptr_s;
  logic       sda_oe_r, sda_oe_s;
  logic       wr_en_r, wr_en_s;
  logic [7:0] wr_addr_r, wr_addr_s;
  logic [7:0] wr_data_r, wr_data_s;
  logic       busy_r, busy_s;

  i2c_bus_sync u_sync (
    .clock       (clock),
    .reset       (reset),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda_s       (sda_s),
    .scl_rise_s  (scl_rise_s),
    .scl_fall_s  (scl_fall_s),
    .start_det_s (start_det_s),
    .stop_det_s  (stop_det_s)
  );

  assign byte_in_s = {shift_r[6:0], sda_s};

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers; every output is driven straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r     <= 4'd0;
      shift_r   <= 8'h00;
      ptr_r     <= 8'h00;
      sda_oe_r  <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 8'h00;
      wr_data_r <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      shift_r   <= shift_s;
      ptr_r     <= ptr_s;
      sda_oe_r  <= sda_oe_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      busy_r    <= busy_s;
    end
  end

  // Next-state logic; bus conditions override any partially shifted byte.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    shift_s   = shift_r;
    ptr_s     = ptr_r;
    sda_oe_s  = sda_oe_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    busy_s    = busy_r;
    if (stop_det_s) begin
      state_s  = IDLE;
      cnt_s    = 4'd0;
      sda_oe_s = 1'b0;
      busy_s   = 1'b0;
    end else if (start_det_s) begin
      state_s  = ADDR;
      cnt_s    = 4'd0;
      sda_oe_s = 1'b0;
      busy_s   = 1'b0;
    end else begin
      case (state_r)
        ADDR, REG, WDATA: begin
          if (scl_rise_s && (cnt_r < LAST_CNT)) begin
            shift_s = byte_in_s;
            cnt_s   = cnt_r + 4'd1;
            if ((state_r == WDATA) && (cnt_r == (LAST_CNT - 4'd1))) begin
              wr_en_s   = 1'b1;
              wr_addr_s = ptr_r;
              wr_data_s = byte_in_s;
              ptr_s     = AUTOINC ? (ptr_r + 8'd1) : ptr_r;
            end else begin
              wr_en_s = 1'b0;
            end
          end else if (scl_fall_s && (cnt_r == LAST_CNT)) begin
            cnt_s = 4'd0;
            case (state_r)
              ADDR: begin
                if (addr_match(shift_r, DEV_ADDR)) begin
                  sda_oe_s = 1'b1;
                  busy_s   = 1'b1;
                  state_s  = ADDR_ACK;
                end else begin
                  state_s  = WAIT_STOP;
                end
              end
              REG: begin
                ptr_s    = shift_r;
                sda_oe_s = 1'b1;
                state_s  = REG_ACK;
              end
              default: begin
                sda_oe_s = 1'b1;
                state_s  = WDATA_ACK;
              end
            endcase
          end else begin
            cnt_s = cnt_r;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            cnt_s = 4'd0;
            if (shift_r[0]) begin
              shift_s  = rd_data;
              sda_oe_s = ~rd_data[7];
              state_s  = RDATA;
            end else begin
              sda_oe_s = 1'b0;
              state_s  = REG;
            end
          end else begin
            state_s = ADDR_ACK;
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall_s) begin
            cnt_s    = 4'd0;
            sda_oe_s = 1'b0;
            state_s  = WDATA;
          end else begin
            state_s = state_r;
          end
        end
        RDATA: begin
          if (scl_rise_s && (cnt_r < LAST_CNT)) begin
            cnt_s = cnt_r + 4'd1;
          end else if (scl_fall_s && (cnt_r == LAST_CNT)) begin
            cnt_s    = 4'd0;
            sda_oe_s = 1'b0;
            state_s  = RD_MACK;
          end else if (scl_fall_s) begin
            shift_s  = {shift_r[6:0], 1'b0};
            sda_oe_s = ~shift_r[6];
          end else begin
            cnt_s = cnt_r;
          end
        end
        RD_MACK: begin
          // Pointer advances at the master's acknowledge sample so the reload sees the next register.
          if (scl_rise_s) begin
            ptr_s = AUTOINC ? (ptr_r + 8'd1) : ptr_r;
            if (sda_s == NACK_BIT) begin
              sda_oe_s = 1'b0;
              busy_s   = 1'b0;
              state_s  = WAIT_STOP;
            end else begin
              state_s  = RD_MACK;
            end
          end else if (scl_fall_s) begin
            cnt_s    = 4'd0;
            shift_s  = rd_data;
            sda_oe_s = ~rd_data[7];
            state_s  = RDATA;
          end else begin
            state_s = RD_MACK;
          end
        end
        IDLE, WAIT_STOP: begin
          state_s = state_r;
        end
        default: begin
          state_s  = IDLE;
          sda_oe_s = 1'b0;
          busy_s   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = sda_oe_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign rd_addr = ptr_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: bus master tasks, open-drain SDA model, write log.
module tb_i2c_target_responder;
  import i2c_pkg::*;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam int Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in, sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h2A;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int busy_hits = 0;
  logic [7:0] log_addr [0:31];
  logic [7:0] log_data [0:31];

  always #5 clock = ~clock;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_responder #(.DEV_ADDR(7'h1D)) dut (
    .clock   (clock),
    .reset   (reset),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      log_addr[wr_cnt[4:0]] <= wr_addr;
      log_data[wr_cnt[4:0]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (busy === 1'b1) busy_hits <= busy_hits + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (Q) @(negedge clock);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;
    half();
    scl_m = 1'b1;
    repeat (Q / 2) @(negedge clock);
    s = sda_in;
    repeat (Q / 2) @(negedge clock);
    scl_m = 1'b0;
    half();
  endtask

  task automatic bus_bits(input logic [7:0] d, input int n, output logic [7:0] rx);
    logic s;
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus_bit(d[i], s);
      rx[i] = s;
    end
  endtask

  task automatic bus_byte(input logic [7:0] d, output logic ack);
    logic [7:0] rx;
    bus_bits(d, 8, rx);
    bus_bit(1'b1, ack);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    half();
    scl_m = 1'b1;
    half();
    sda_m = 1'b0;
    half();
    scl_m = 1'b0;
    half();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    half();
    scl_m = 1'b1;
    half();
    sda_m = 1'b1;
    half();
    half();
  endtask

  initial begin
    logic       ack;
    logic [7:0] rx;
    int         wb;
    int         bh;

    repeat (4) @(negedge clock);
    check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("rst_wr_en", {7'd0, wr_en}, 8'h00);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_rd_addr", rd_addr, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    half();

    // Single register write 0x20 <= 0x57.
    wb = wr_cnt;
    bus_start();
    bus_byte(8'h3A, ack);
    check("w1_ack_addr", {7'd0, ack}, 8'h00);
    check("w1_busy_on", {7'd0, busy}, 8'h01);
    bus_byte(8'h20, ack);
    check("w1_ack_reg", {7'd0, ack}, 8'h00);
    bus_byte(8'h57, ack);
    check("w1_ack_data", {7'd0, ack}, 8'h00);
    bus_stop();
    check("w1_wr_count", 8'(wr_cnt - wb), 8'h01);
    check("w1_wr_addr", log_addr[wb], 8'h20);
    check("w1_wr_data", log_data[wb], 8'h57);
    check("w1_busy_off", {7'd0, busy}, 8'h00);
    check("w1_rd_addr", rd_addr, AUTOINC ? 8'h21 : 8'h20);

    // Pointer set, repeated start, read one byte, master NACK.
    wb = wr_cnt;
    bus_start();
    bus_byte(8'h3A, ack);
    check("r1_ack_addr", {7'd0, ack}, 8'h00);
    bus_byte(8'h0F, ack);
    check("r1_ack_reg", {7'd0, ack}, 8'h00);
    bus_start();
    bus_byte(8'h3B, ack);
    check("r1_ack_raddr", {7'd0, ack}, 8'h00);
    check("r1_rd_addr", rd_addr, 8'h0F);
    bus_bits(8'hFF, 8, rx);
    check("r1_rx_byte", rx, 8'h2A);
    bus_bit(1'b1, ack);
    check("r1_nack_line", {7'd0, ack}, 8'h01);
    check("r1_sda_oe_nack", {7'd0, sda_oe}, 8'h00);
    check("r1_busy_nack", {7'd0, busy}, 8'h00);
    bus_stop();
    check("r1_wr_count", 8'(wr_cnt - wb), 8'h00);
    check("r1_rd_addr_end", rd_addr, AUTOINC ? 8'h10 : 8'h0F);

    // Foreign address 0x50: ignored entirely.
    wb = wr_cnt;
    bh = busy_hits;
    bus_start();
    bus_byte(8'hA0, ack);
    check("na_ack_addr", {7'd0, ack}, 8'h01);
    bus_byte(8'h12, ack);
    check("na_ack_reg", {7'd0, ack}, 8'h01);
    bus_stop();
    check("na_busy_hits", 8'(busy_hits - bh), 8'h00);
    check("na_wr_count", 8'(wr_cnt - wb), 8'h00);

    // Two data bytes from pointer 0xFF.
    wb = wr_cnt;
    bus_start();
    bus_byte(8'h3A, ack);
    check("ai_ack_addr", {7'd0, ack}, 8'h00);
    bus_byte(8'hFF, ack);
    check("ai_ack_reg", {7'd0, ack}, 8'h00);
    bus_byte(8'h11, ack);
    check("ai_ack_d0", {7'd0, ack}, 8'h00);
    bus_byte(8'h22, ack);
    check("ai_ack_d1", {7'd0, ack}, 8'h00);
    bus_stop();
    check("ai_wr_count", 8'(wr_cnt - wb), 8'h02);
    check("ai_wr_addr0", log_addr[wb], 8'hFF);
    check("ai_wr_data0", log_data[wb], 8'h11);
    check("ai_wr_addr1", log_addr[wb + 1], AUTOINC ? 8'h00 : 8'hFF);
    check("ai_wr_data1", log_data[wb + 1], 8'h22);

    // STOP after four bits of a data byte.
    wb = wr_cnt;
    bus_start();
    bus_byte(8'h3A, ack);
    bus_byte(8'h40, ack);
    check("pb_ack_reg", {7'd0, ack}, 8'h00);
    bus_bits(8'hB0, 4, rx);
    bus_stop();
    check("pb_wr_count", 8'(wr_cnt - wb), 8'h00);
    check("pb_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("pb_busy", {7'd0, busy}, 8'h00);
    check("pb_rd_addr", rd_addr, 8'h40);

    // Reset while driving the address ACK, then a clean write.
    bus_start();
    bus_bits(8'h3A, 8, rx);
    check("rs_ack_drive", {7'd0, sda_oe}, 8'h01);
    reset = 1'b1;
    @(negedge clock);
    check("rs_sda_oe_rel", {7'd0, sda_oe}, 8'h00);
    check("rs_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    half();
    bus_stop();
    wb = wr_cnt;
    bus_start();
    bus_byte(8'h3A, ack);
    check("rs_ack_addr", {7'd0, ack}, 8'h00);
    bus_byte(8'h05, ack);
    check("rs_ack_reg", {7'd0, ack}, 8'h00);
    bus_byte(8'h99, ack);
    check("rs_ack_data", {7'd0, ack}, 8'h00);
    bus_stop();
    check("rs_wr_count", 8'(wr_cnt - wb), 8'h01);
    check("rs_wr_addr", log_addr[wb], 8'h05);
    check("rs_wr_data", log_data[wb], 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
